rf_read_sched: RTL and testbench
================================

# rf_read_sched

Operand-fetch scheduler for the 8-entry x 8-bit register file, which has one combinational read port and one write port. It accepts decoded instructions, reads rs1 then rs2 through the single read port over two cycles, and routes writeback traffic to the write port. A pending-write scoreboard stalls reads of registers whose results are still in flight. It sits between decode and execute in the 4-stage pipeline.

## Interface
- DW, 8, register data width
- AW, 3, register index width (2^AW registers)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  decoded instruction available
- req_ready  out  1  scheduler can accept an instruction
- req_rs1, req_rs2  in  AW  source register indices
- req_rd  in  AW  destination register index
- req_wen  in  1  instruction will write req_rd
- rf_read_reg  out  AW  drives the register file read index
- rf_read_data  in  DW  register file read data, combinational from rf_read_reg
- rf_write_reg  out  AW  drives the register file write index
- rf_write_data  out  DW  drives the register file write data
- rf_reg_write  out  1  register file write enable
- wb_valid  in  1  writeback result valid this cycle
- wb_reg  in  AW  writeback destination
- wb_data  in  DW  writeback data
- op_valid  out  1  operands presented to execute
- op_ready  in  1  execute accepts operands
- op_a, op_b  out  DW  operand values for rs1 and rs2
- op_rd  out  AW  destination passed through
- op_wen  out  1  write intent passed through
- stall_cnt  out  16  count of stalled read cycles, saturating

## Operation
- The block has four states: IDLE, RD1, RD2, OUT.
- **IDLE:** req_ready=1. When req_valid=1, the block captures rs1, rs2, rd and wen, then goes to RD1.
- **RD1:** rf_read_reg=rs1.
  - The read is blocked when busy[rs1]=1 and there is no forward hit. A forward hit is wb_valid=1 and wb_reg=rs1.
  - While blocked, the block stays in RD1 and increments stall_cnt.
  - Otherwise op_a is loaded with wb_data on a forward hit, else with rf_read_data. The block then goes to RD2.
- **RD2:** identical to RD1, but uses rs2 and loads op_b. It then goes to OUT.
- **OUT:** op_valid=1.
  - When op_ready=1: if wen=1, set busy[rd]. Then go to IDLE.
  - op_a, op_b, op_rd and op_wen are held stable while op_valid=1 and op_ready=0.
- **Write port:** pure pass-through.
  - rf_reg_write=wb_valid, rf_write_reg=wb_reg, rf_write_data=wb_data.
  - This applies in every state, including during reset.
- **Scoreboard:** busy is 8 bits, one per register.
  - wb_valid=1 clears busy[wb_reg].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - A writeback to a non-busy register is legal: it writes the register file and leaves busy unchanged.
- **rs1 = rs2:** the register is read twice, with the same stall rules applied to each read.
- **rd equal to rs1 or rs2:** busy is set only on issue (OUT handshake), so an instruction never stalls on its own destination.
- **stall_cnt:** saturates at 16'hFFFF.
- **Reset:**
  - State returns to IDLE.
  - busy=0.
  - op_a=op_b=0, op_rd=0, op_wen=0.
  - stall_cnt=0.
  - Outputs: req_ready=1, op_valid=0.
  - rf_read_reg=0 (RD1/RD2 index registers cleared).
- **Reset mid-operation:** the in-flight instruction is dropped. Writebacks arriving after reset still write the register file, and busy stays 0.

## Timing
- The earliest accept is in cycle N (IDLE with req_valid).
- RD1 is cycle N+1, RD2 is cycle N+2, and op_valid=1 in cycle N+3.
- With op_ready held at 1, throughput is one instruction per 4 cycles.
- Each blocked cycle in RD1 or RD2 adds one cycle of latency.
- Forwarding has zero extra latency: the value is taken in the same cycle as the writeback.
- req_ready is combinational from state only. It never depends on req_valid.

## Configuration
- RFSCHED_FWD_EN
  - **Defined:** same-cycle writeback forwarding, as described above.
  - **Undefined:** no forwarding. A read is blocked whenever busy[src]=1. It proceeds from rf_read_data in the cycle after the writeback cleared busy.
  - Each forwarded read therefore costs one extra cycle and one stall_cnt increment.

## Test plan
- **Reset-value read:** apply reset with the register file at reset values (Rn=n). Issue rs1=3, rs2=5, rd=1, wen=1 with op_ready=1. Required: op_valid in cycle N+3 with op_a=3, op_b=5, op_rd=1; busy[1]=1 afterwards.
- **Scoreboard stall:** issue a write to rd=2. Then issue rs1=2, rs2=4; the scheduler must hold in RD1. Drive wb_valid with wb_reg=2 and wb_data=8'hA5 three cycles later.
  - With the macro: op_a=A5, stall_cnt=3.
  - Without the macro: op_a=A5, stall_cnt=4.
- **Output backpressure:** hold op_ready=0 for 5 cycles. Required: op_valid stays 1, all operand outputs are stable, req_ready=0, and busy is not set until op_ready=1.
- **Simultaneous set/clear:** in the OUT handshake cycle for rd=6, wen=1, also drive wb_valid with wb_reg=6. Required: busy[6]=1 after the edge, and the register file is written.
- **Reset mid-operation:** assert rst while in RD2 with busy[2]=1. Required: immediate IDLE, req_ready=1, op_valid=0, busy=0, stall_cnt=0.
- **stall_cnt saturation:** force 70000 blocked cycles. Required: stall_cnt=FFFF with no wrap to 0.

Source files
------------

// File: rtl/rf_read_sched_if.sv
// rf_read_sched_if
//   Bundles the operand-fetch scheduler's bus signals: the decode request
//   handshake, the register-file read and write ports, the writeback input
//   and the execute operand handshake.
//   Parameters: DW register data width, AW register index width.
//   Modports:
//     slave  - the scheduler (rf_read_sched)
//     master - the surrounding pipeline / register file
interface rf_read_sched_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  // decode -> scheduler
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rs1;
  logic [AW-1:0] req_rs2;
  logic [AW-1:0] req_rd;
  logic          req_wen;
  // register file ports
  logic [AW-1:0] rf_read_reg;
  logic [DW-1:0] rf_read_data;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic          rf_reg_write;
  // writeback
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  // scheduler -> execute
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [AW-1:0] op_rd;
  logic          op_wen;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wen,
    output req_ready,
    output rf_read_reg,
    input  rf_read_data,
    output rf_write_reg, rf_write_data, rf_reg_write,
    input  wb_valid, wb_reg, wb_data,
    output op_valid, op_a, op_b, op_rd, op_wen,
    input  op_ready
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_wen,
    input  req_ready,
    input  rf_read_reg,
    output rf_read_data,
    input  rf_write_reg, rf_write_data, rf_reg_write,
    output wb_valid, wb_reg, wb_data,
    input  op_valid, op_a, op_b, op_rd, op_wen,
    output op_ready
  );
endinterface

// File: rtl/rf_read_sched.sv
// rf_read_sched
//   Operand-fetch scheduler for a 2^AW x DW register file with one
//   combinational read port and one write port. An accepted instruction
//   reads rs1 then rs2 through the single read port (RD1, RD2), then
//   presents both operands to execute (OUT). A pending-write scoreboard
//   (one busy bit per register) stalls reads of registers whose results
//   are still in flight; busy is set when an instruction with wen issues
//   and cleared by the matching writeback. Writeback traffic is passed
//   straight through to the register-file write port.
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous reset, active-high
//     bus        rf_read_sched_if.slave (request, rf ports, writeback, operands)
//     stall_cnt  saturating count of blocked read cycles
//
//   Configuration macro RFSCHED_FWD_EN:
//     defined   - a writeback to the source register in the same cycle is
//                 forwarded into the operand, so the read does not stall.
//     undefined - a busy source always blocks; the read completes from the
//                 register file the cycle after the writeback clears busy.
module rf_read_sched #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  rf_read_sched_if.slave bus,
  output logic [15:0]  stall_cnt
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t          stateR;
  logic [AW-1:0]   rs1R;
  logic [AW-1:0]   rs2R;
  logic [AW-1:0]   rdR;
  logic            wenR;
  logic [NREG-1:0] busyR;
  logic [DW-1:0]   opAR;
  logic [DW-1:0]   opBR;
  logic [AW-1:0]   opRdR;
  logic            opWenR;
  logic            opValidR;
  logic [15:0]     stallCntR;

  logic [AW-1:0]   srcS;
  logic            blockedS;
  logic [DW-1:0]   readDataS;
  logic            issueS;
  logic [NREG-1:0] clrMaskS;
  logic [NREG-1:0] setMaskS;
  logic [NREG-1:0] busyNextS;

  // Write port is a pure pass-through, independent of state and reset.
  assign bus.rf_reg_write  = bus.wb_valid;
  assign bus.rf_write_reg  = bus.wb_reg;
  assign bus.rf_write_data = bus.wb_data;

  // Read index follows the current source; IDLE/OUT show rs1 (0 after reset).
  assign srcS            = (stateR == RD2) ? rs2R : rs1R;
  assign bus.rf_read_reg = srcS;

  assign bus.req_ready = (stateR == IDLE);
  assign bus.op_valid  = opValidR;
  assign bus.op_a      = opAR;
  assign bus.op_b      = opBR;
  assign bus.op_rd     = opRdR;
  assign bus.op_wen    = opWenR;
  assign stall_cnt     = stallCntR;

  // Decide whether the current source read is blocked and where its data comes from.
  always_comb begin
    blockedS  = 1'b0;
    readDataS = bus.rf_read_data;
`ifdef RFSCHED_FWD_EN
    if (bus.wb_valid && (bus.wb_reg == srcS)) begin
      blockedS  = 1'b0;
      readDataS = bus.wb_data;
    end else begin
      blockedS  = busyR[srcS];
      readDataS = bus.rf_read_data;
    end
`else
    blockedS  = busyR[srcS];
    readDataS = bus.rf_read_data;
`endif
  end

  // Scoreboard next value: clear on writeback, set on issue; set applied last so it wins.
  always_comb begin
    issueS    = (stateR == OUT) && bus.op_ready && wenR;
    clrMaskS  = bus.wb_valid ? (NREG'(1) << bus.wb_reg) : {NREG{1'b0}};
    setMaskS  = issueS ? (NREG'(1) << rdR) : {NREG{1'b0}};
    busyNextS = (busyR & ~clrMaskS) | setMaskS;
  end

  // Scheduler FSM, scoreboard, operand registers and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR    <= IDLE;
      rs1R      <= {AW{1'b0}};
      rs2R      <= {AW{1'b0}};
      rdR       <= {AW{1'b0}};
      wenR      <= 1'b0;
      busyR     <= {NREG{1'b0}};
      opAR      <= {DW{1'b0}};
      opBR      <= {DW{1'b0}};
      opRdR     <= {AW{1'b0}};
      opWenR    <= 1'b0;
      opValidR  <= 1'b0;
      stallCntR <= 16'h0000;
    end else begin
      busyR <= busyNextS;
      case (stateR)
        IDLE: begin
          if (bus.req_valid) begin
            rs1R   <= bus.req_rs1;
            rs2R   <= bus.req_rs2;
            rdR    <= bus.req_rd;
            wenR   <= bus.req_wen;
            stateR <= RD1;
          end else begin
            stateR <= IDLE;
          end
        end
        RD1, RD2: begin
          if (blockedS) begin
            stallCntR <= (stallCntR == 16'hFFFF) ? stallCntR : stallCntR + 16'd1;
          end else if (stateR == RD1) begin
            opAR   <= readDataS;
            stateR <= RD2;
          end else begin
            opBR     <= readDataS;
            opRdR    <= rdR;
            opWenR   <= wenR;
            opValidR <= 1'b1;
            stateR   <= OUT;
          end
        end
        OUT: begin
          // Operands stay frozen until execute takes them.
          if (bus.op_ready) begin
            opValidR <= 1'b0;
            stateR   <= IDLE;
          end else begin
            stateR <= OUT;
          end
        end
        default: begin
          opValidR <= 1'b0;
          stateR   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_read_sched.sv
// tb_rf_read_sched
//   Directed bench for rf_read_sched. Models an 8 x 8 register file whose
//   entries start at Rn = n, drives decode/writeback/execute signals, and
//   checks outputs #1 after each rising edge against hand-computed values.
module tb_rf_read_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stall_cnt;
  logic        rfInit;
  logic [7:0]  rf [8];
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;

  rf_read_sched_if #(.DW(8), .AW(3)) bus ();

  rf_read_sched #(.DW(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // register file model: combinational read, clocked write
  assign bus.rf_read_data = rf[bus.rf_read_reg];
  always @(posedge clk) begin
    if (rfInit) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'(i);
    end else if (bus.rf_reg_write) begin
      rf[bus.rf_write_reg] <= bus.rf_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic wen);
    bus.req_valid = 1'b1;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    bus.req_rd = rd;
    bus.req_wen = wen;
    #1;
    chk("issue_req_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic waitOp(output int cycles);
    cycles = 0;
    while (bus.op_valid !== 1'b1 && cycles < 64) begin
      step();
      cycles++;
    end
    chk("wait_op_valid", bus.op_valid, 1'b1);
  endtask

  task automatic drvWb(input logic [2:0] r, input logic [7:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_reg = r;
    bus.wb_data = d;
  endtask

  initial begin
    rst = 1'b1;
    rfInit = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rs1 = 3'd0;
    bus.req_rs2 = 3'd0;
    bus.req_rd = 3'd0;
    bus.req_wen = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_reg = 3'd0;
    bus.wb_data = 8'h00;
    bus.op_ready = 1'b1;
    step();
    rfInit = 1'b0;

    // reset state and write pass-through while in reset
    drvWb(3'd7, 8'h77);
    #1;
    chk("rst_rf_wen", bus.rf_reg_write, 1'b1);
    chk("rst_rf_wreg", bus.rf_write_reg, 3'd7);
    chk("rst_rf_wdata", bus.rf_write_data, 8'h77);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_op_valid", bus.op_valid, 1'b0);
    chk("rst_stall", stall_cnt, 16'h0000);
    chk("rst_op_a", bus.op_a, 8'h00);
    chk("rst_op_b", bus.op_b, 8'h00);
    chk("rst_op_rd", bus.op_rd, 3'd0);
    chk("rst_op_wen", bus.op_wen, 1'b0);
    chk("rst_rd_idx", bus.rf_read_reg, 3'd0);
    chk("rst_busy", dut.busyR, 8'h00);
    step();
    bus.wb_valid = 1'b0;
    rst = 1'b0;
    chk("rst_rf7_written", rf[7], 8'h77);

    // reset-value read: rs1=3 rs2=5 rd=1 wen=1
    issue(3'd3, 3'd5, 3'd1, 1'b1);
    chk("t1_rd1_idx", bus.rf_read_reg, 3'd3);
    chk("t1_rd1_req_ready", bus.req_ready, 1'b0);
    chk("t1_rd1_op_valid", bus.op_valid, 1'b0);
    step();
    chk("t1_rd2_idx", bus.rf_read_reg, 3'd5);
    chk("t1_rd2_op_valid", bus.op_valid, 1'b0);
    step();
    chk("t1_op_valid", bus.op_valid, 1'b1);
    chk("t1_op_a", bus.op_a, 8'h03);
    chk("t1_op_b", bus.op_b, 8'h05);
    chk("t1_op_rd", bus.op_rd, 3'd1);
    chk("t1_op_wen", bus.op_wen, 1'b1);
    chk("t1_busy_pre", dut.busyR, 8'h00);
    step();
    chk("t1_done_op_valid", bus.op_valid, 1'b0);
    chk("t1_done_req_ready", bus.req_ready, 1'b1);
    chk("t1_busy_post", dut.busyR, 8'h02);

    // scoreboard stall: writer to r2 (also rs1 = rs2 = r0), then reader of r2
    issue(3'd0, 3'd0, 3'd2, 1'b1);
    waitOp(lat);
    chk("t2w_lat", lat, 2);
    chk("t2w_op_a", bus.op_a, 8'h00);
    chk("t2w_op_b", bus.op_b, 8'h00);
    chk("t2w_stall", stall_cnt, 16'h0000);
    step();
    chk("t2w_busy", dut.busyR, 8'h06);
    issue(3'd2, 3'd4, 3'd3, 1'b0);
    repeat (3) step();
    chk("t2_stall3", stall_cnt, 16'h0003);
    chk("t2_hold_idx", bus.rf_read_reg, 3'd2);
    chk("t2_hold_op_valid", bus.op_valid, 1'b0);
    drvWb(3'd2, 8'hA5);
    #1;
    chk("t2_wb_wen", bus.rf_reg_write, 1'b1);
    chk("t2_wb_wreg", bus.rf_write_reg, 3'd2);
    chk("t2_wb_wdata", bus.rf_write_data, 8'hA5);
    step();
    bus.wb_valid = 1'b0;
    waitOp(lat);
`ifdef RFSCHED_FWD_EN
    chk("t2_lat", lat, 1);
    chk("t2_stall", stall_cnt, 16'h0003);
`else
    chk("t2_lat", lat, 2);
    chk("t2_stall", stall_cnt, 16'h0004);
`endif
    chk("t2_op_a", bus.op_a, 8'hA5);
    chk("t2_op_b", bus.op_b, 8'h04);
    chk("t2_op_rd", bus.op_rd, 3'd3);
    chk("t2_op_wen", bus.op_wen, 1'b0);
    step();
    chk("t2_busy", dut.busyR, 8'h02);

    // output backpressure for 5 cycles
    bus.op_ready = 1'b0;
    issue(3'd6, 3'd7, 3'd5, 1'b1);
    waitOp(lat);
    chk("t3_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      chk("t3_op_valid", bus.op_valid, 1'b1);
      chk("t3_op_a", bus.op_a, 8'h06);
      chk("t3_op_b", bus.op_b, 8'h77);
      chk("t3_op_rd", bus.op_rd, 3'd5);
      chk("t3_op_wen", bus.op_wen, 1'b1);
      chk("t3_req_ready", bus.req_ready, 1'b0);
      chk("t3_busy_held", dut.busyR, 8'h02);
      step();
    end
    bus.op_ready = 1'b1;
    #1;
    step();
    chk("t3_done_op_valid", bus.op_valid, 1'b0);
    chk("t3_busy", dut.busyR, 8'h22);

    // simultaneous set and clear of busy[6]
    issue(3'd0, 3'd3, 3'd6, 1'b1);
    waitOp(lat);
    chk("t4_op_b", bus.op_b, 8'h03);
    drvWb(3'd6, 8'h66);
    step();
    bus.wb_valid = 1'b0;
    chk("t4_busy", dut.busyR, 8'h62);
    chk("t4_rf6", rf[6], 8'h66);
    chk("t4_op_valid", bus.op_valid, 1'b0);

    // reset mid-operation while in RD2 with busy[2] set
    issue(3'd0, 3'd0, 3'd2, 1'b1);
    waitOp(lat);
    step();
    chk("t5_busy_pre", dut.busyR, 8'h66);
    issue(3'd0, 3'd3, 3'd0, 1'b0);
    step();
    chk("t5_in_rd2_idx", bus.rf_read_reg, 3'd3);
    rst = 1'b1;
    #1;
    chk("t5_req_ready", bus.req_ready, 1'b1);
    chk("t5_op_valid", bus.op_valid, 1'b0);
    chk("t5_busy", dut.busyR, 8'h00);
    chk("t5_stall", stall_cnt, 16'h0000);
    chk("t5_rd_idx", bus.rf_read_reg, 3'd0);
    chk("t5_op_a", bus.op_a, 8'h00);
    step();
    rst = 1'b0;
    drvWb(3'd2, 8'h22);
    step();
    bus.wb_valid = 1'b0;
    chk("t5_wb_busy", dut.busyR, 8'h00);
    chk("t5_wb_rf2", rf[2], 8'h22);
    chk("t5_wb_req_ready", bus.req_ready, 1'b1);

    // stall_cnt saturation: 70000 blocked cycles on r4
    issue(3'd0, 3'd0, 3'd4, 1'b1);
    waitOp(lat);
    step();
    chk("t6_busy", dut.busyR, 8'h10);
    issue(3'd4, 3'd1, 3'd0, 1'b0);
    repeat (65534) step();
    chk("t6_stall_fffe", stall_cnt, 16'hFFFE);
    repeat (70000 - 65534) step();
    chk("t6_stall_sat", stall_cnt, 16'hFFFF);
    chk("t6_op_valid", bus.op_valid, 1'b0);
    drvWb(3'd4, 8'h44);
    step();
    bus.wb_valid = 1'b0;
    waitOp(lat);
    chk("t6_op_a", bus.op_a, 8'h44);
    chk("t6_op_b", bus.op_b, 8'h01);
    chk("t6_stall_end", stall_cnt, 16'hFFFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
